branch_resolve_unit: RTL and testbench

Parametrised branch-decision block for the RV32I core. It resolves all six RV32I conditional branches plus unconditional jumps from ALU flags in EX, and keeps a direct-mapped table of 2-bit saturating counters that provides a taken/not-taken prediction to IF. It raises a mispredict flush when the outcome disagrees with the prediction carried down the pipe. It also keeps saturating branch and mispredict statistics counters.

---
 rtl/branch_resolve_unit_if.sv | 38 +++
 rtl/branch_resolve_unit.sv | 106 ++++++++++
 tb/tb_branch_resolve_unit.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_if.sv
// Branch resolve unit bundle: the IF-stage prediction lookup, the EX-stage
// resolution inputs and ALU flags, and the resolved outputs and statistics.
//   slave  : the branch_resolve_unit side (consumes EX/IF inputs, drives results)
//   master : the pipeline side (drives EX/IF inputs, consumes results)
// CNT_W must match the CNT_W of the attached branch_resolve_unit.
interface branch_resolve_unit_if #(
    parameter int unsigned CNT_W = 32
);
    logic [31:0]      if_pc;
    logic             if_pred_taken;
    logic             ex_valid;
    logic [31:0]      ex_pc;
    logic             ex_branch;
    logic             ex_jump;
    logic [2:0]       ex_funct3;
    logic             ex_pred_taken;
    logic             ZF;
    logic             SF;
    logic             OF;
    logic             CF;
    logic             PCSrc;
    logic             mispredict;
    logic             illegal_funct3;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mispred_count;

    modport slave (
        input  if_pc, ex_valid, ex_pc, ex_branch, ex_jump, ex_funct3, ex_pred_taken,
               ZF, SF, OF, CF,
        output if_pred_taken, PCSrc, mispredict, illegal_funct3, br_count, mispred_count
    );

    modport master (
        output if_pc, ex_valid, ex_pc, ex_branch, ex_jump, ex_funct3, ex_pred_taken,
               ZF, SF, OF, CF,
        input  if_pred_taken, PCSrc, mispredict, illegal_funct3, br_count, mispred_count
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// RV32I branch resolution and 2-bit saturating-counter branch predictor.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset (table to INIT_STATE, statistics to 0)
//   bus  : branch_resolve_unit_if.slave
//          if_pc -> if_pred_taken        combinational prediction lookup
//          ex_* + ZF/SF/OF/CF -> PCSrc, mispredict, illegal_funct3 (combinational)
//          br_count, mispred_count       saturating statistics counters
module branch_resolve_unit #(
    parameter int unsigned IDX_W      = 6,
    parameter int unsigned CNT_W      = 32,
    parameter logic [1:0]  INIT_STATE = 2'b01
) (
    input logic                 clk,
    input logic                 rst,
    branch_resolve_unit_if.slave bus
);
    localparam int ENTRIES = 2 ** IDX_W;

    logic [1:0]       pht_q [ENTRIES];
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             cond;
    logic             bad_funct3;
    logic             taken;
    logic             illegal;
    logic             pcsrc;
    logic             mispred;
    logic             resolve;
    logic             update;
    logic [1:0]       ctr_cur;
    logic [1:0]       ctr_d;
    logic [CNT_W-1:0] br_count_q, br_count_d;
    logic [CNT_W-1:0] mispred_count_q, mispred_count_d;
    logic             unused_pc;

    // PC byte offset and bits above the index do not take part in the lookup.
    assign unused_pc = ^{bus.if_pc[31:IDX_W+2], bus.if_pc[1:0],
                         bus.ex_pc[31:IDX_W+2], bus.ex_pc[1:0]};

    assign if_idx = bus.if_pc[IDX_W+1:2];
    assign ex_idx = bus.ex_pc[IDX_W+1:2];

    // Branch condition decode from rs1-rs2 flags.
    always_comb begin
        cond       = 1'b0;
        bad_funct3 = 1'b0;
        case (bus.ex_funct3)
            3'b000:  cond = bus.ZF;
            3'b001:  cond = ~bus.ZF;
            3'b100:  cond = bus.SF ^ bus.OF;
            3'b101:  cond = ~(bus.SF ^ bus.OF);
            3'b110:  cond = bus.CF;
            3'b111:  cond = ~bus.CF;
            default: bad_funct3 = 1'b1;
        endcase
    end

    always_comb begin
        taken   = bus.ex_valid & bus.ex_branch & cond;
        illegal = bus.ex_valid & bus.ex_branch & bad_funct3;
        pcsrc   = taken | (bus.ex_valid & bus.ex_jump);
        resolve = bus.ex_valid & (bus.ex_branch | bus.ex_jump);
        mispred = resolve & (pcsrc != bus.ex_pred_taken);
        // A jump with ex_branch also set is still a jump: it never trains the table.
        update  = bus.ex_valid & bus.ex_branch & ~bus.ex_jump & ~bad_funct3;
    end

    always_comb begin
        ctr_cur = pht_q[ex_idx];
        ctr_d   = ctr_cur;
        if (taken) begin
            if (ctr_cur != 2'b11) ctr_d = ctr_cur + 2'd1;
        end else begin
            if (ctr_cur != 2'b00) ctr_d = ctr_cur - 2'd1;
        end
    end

    always_comb begin
        br_count_d      = br_count_q;
        mispred_count_d = mispred_count_q;
        if (resolve && (br_count_q != '1)) br_count_d = br_count_q + CNT_W'(1);
        if (mispred && (mispred_count_q != '1)) mispred_count_d = mispred_count_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) pht_q[i] <= INIT_STATE;
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            if (update) pht_q[ex_idx] <= ctr_d;
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    // Lookup reads the registered table: a same-cycle update to the same entry
    // is not forwarded.
    assign bus.if_pred_taken  = pht_q[if_idx][1];
    assign bus.PCSrc          = pcsrc;
    assign bus.mispredict     = mispred;
    assign bus.illegal_funct3 = illegal;
    assign bus.br_count       = br_count_q;
    assign bus.mispred_count  = mispred_count_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    branch_resolve_unit_if                  bus  ();
    branch_resolve_unit_if #(.CNT_W(4))     bus4 ();

    branch_resolve_unit #(.IDX_W(6), .CNT_W(32), .INIT_STATE(2'b01)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    branch_resolve_unit #(.IDX_W(6), .CNT_W(4), .INIT_STATE(2'b01)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    typedef struct {
        string       name;
        bit          sel4;
        bit          chk_comb;
        logic        pcsrc;
        logic        mis;
        logic        ill;
        bit          chk_pred;
        logic        pred;
        bit          chk_cnt;
        logic [31:0] br;
        logic [31:0] mp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string n, input string f, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s.%s actual=%0h required=%0h", n, f, act, exp);
    endtask

    // Monitor: each cycle, compare all expectations queued for it.
    always @(negedge clk) begin
        exp_t        e;
        logic        a_pc, a_mis, a_ill, a_pred;
        logic [31:0] a_br, a_mp;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.sel4) begin
                a_pc = bus4.PCSrc; a_mis = bus4.mispredict; a_ill = bus4.illegal_funct3;
                a_pred = bus4.if_pred_taken;
                a_br = 32'(bus4.br_count); a_mp = 32'(bus4.mispred_count);
            end else begin
                a_pc = bus.PCSrc; a_mis = bus.mispredict; a_ill = bus.illegal_funct3;
                a_pred = bus.if_pred_taken;
                a_br = bus.br_count; a_mp = bus.mispred_count;
            end
            if (e.chk_comb) begin
                check(e.name, "PCSrc", 32'(a_pc), 32'(e.pcsrc));
                check(e.name, "mispredict", 32'(a_mis), 32'(e.mis));
                check(e.name, "illegal_funct3", 32'(a_ill), 32'(e.ill));
            end
            if (e.chk_pred) check(e.name, "if_pred_taken", 32'(a_pred), 32'(e.pred));
            if (e.chk_cnt) begin
                check(e.name, "br_count", a_br, e.br);
                check(e.name, "mispred_count", a_mp, e.mp);
            end
        end
    end

    function automatic exp_t blank(input string n, input bit s4);
        exp_t e;
        e.name = n; e.sel4 = s4;
        e.chk_comb = 0; e.pcsrc = 0; e.mis = 0; e.ill = 0;
        e.chk_pred = 0; e.pred = 0;
        e.chk_cnt = 0; e.br = 0; e.mp = 0;
        return e;
    endfunction

    task automatic exp_comb(input string n, input bit s4, input logic p, input logic m,
                            input logic i);
        exp_t e;
        e = blank(n, s4);
        e.chk_comb = 1; e.pcsrc = p; e.mis = m; e.ill = i;
        sb.push_back(e);
    endtask

    task automatic exp_pred(input string n, input bit s4, input logic p);
        exp_t e;
        e = blank(n, s4);
        e.chk_pred = 1; e.pred = p;
        sb.push_back(e);
    endtask

    task automatic exp_cnt(input string n, input bit s4, input int br, input int mp);
        exp_t e;
        e = blank(n, s4);
        e.chk_cnt = 1; e.br = 32'(br); e.mp = 32'(mp);
        sb.push_back(e);
    endtask

    task automatic ex(input logic v, input logic b, input logic j, input logic [2:0] f3,
                      input logic [31:0] pc, input logic pt, input logic z, input logic s,
                      input logic o, input logic c);
        bus.ex_valid = v; bus.ex_branch = b; bus.ex_jump = j; bus.ex_funct3 = f3;
        bus.ex_pc = pc; bus.ex_pred_taken = pt;
        bus.ZF = z; bus.SF = s; bus.OF = o; bus.CF = c;
    endtask

    task automatic ex4(input logic v, input logic b, input logic [2:0] f3,
                       input logic [31:0] pc, input logic pt, input logic z);
        bus4.ex_valid = v; bus4.ex_branch = b; bus4.ex_jump = 1'b0; bus4.ex_funct3 = f3;
        bus4.ex_pc = pc; bus4.ex_pred_taken = pt;
        bus4.ZF = z; bus4.SF = 1'b0; bus4.OF = 1'b0; bus4.CF = 1'b0;
    endtask

    task automatic idle();
        ex(0, 0, 0, 3'b000, 32'h0, 0, 0, 0, 0, 0);
    endtask

    // Let the monitor sample this cycle, then advance past the next rising edge.
    task automatic step();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        bus.if_pc = 32'h0;
        ex4(0, 0, 3'b000, 32'h0, 0, 0);
        bus4.if_pc = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Post-reset: every entry weakly not-taken, counters zero.
        exp_cnt("rst_cnt", 0, 0, 0);
        exp_cnt("rst_cnt4", 1, 0, 0);
        for (int pc = 0; pc <= 'hFC; pc += 4) begin
            bus.if_pc = 32'(pc);
            exp_pred($sformatf("rst_pred_%0h", pc), 0, 1'b0);
            step();
        end

        // Condition sweep at 0x80 (entry 32), ex_pred_taken=0.
        bus.if_pc = 32'h0;
        ex(1, 1, 0, 3'b000, 32'h80, 0, 1, 0, 0, 0); exp_comb("beq_z1", 0, 1, 1, 0); step();
        ex(1, 1, 0, 3'b001, 32'h80, 0, 1, 0, 0, 0); exp_comb("bne_z1", 0, 0, 0, 0); step();
        ex(1, 1, 0, 3'b100, 32'h80, 0, 0, 1, 0, 0); exp_comb("blt_s1o0", 0, 1, 1, 0); step();
        ex(1, 1, 0, 3'b101, 32'h80, 0, 0, 1, 0, 0); exp_comb("bge_s1o0", 0, 0, 0, 0); step();
        ex(1, 1, 0, 3'b100, 32'h80, 0, 0, 1, 1, 0); exp_comb("blt_s1o1", 0, 0, 0, 0); step();
        ex(1, 1, 0, 3'b110, 32'h80, 0, 0, 0, 0, 1); exp_comb("bltu_c1", 0, 1, 1, 0); step();
        ex(1, 1, 0, 3'b111, 32'h80, 0, 0, 0, 0, 1); exp_comb("bgeu_c1", 0, 0, 0, 0); step();
        // Illegal funct3 at 0xC0 must not move entry 48 off 01.
        ex(1, 1, 0, 3'b010, 32'hC0, 0, 1, 0, 0, 0); exp_comb("ill_010", 0, 0, 0, 1); step();
        ex(1, 1, 0, 3'b011, 32'hC0, 0, 1, 0, 0, 0); exp_comb("ill_011", 0, 0, 0, 1); step();
        ex(1, 1, 0, 3'b000, 32'hC0, 0, 1, 0, 0, 0); exp_comb("beq_c0", 0, 1, 1, 0); step();
        idle();
        bus.if_pc = 32'hC0; exp_pred("c0_after_ill", 0, 1'b1); exp_cnt("cnt_sweep", 0, 10, 4);
        step();
        bus.if_pc = 32'h80; exp_pred("pred_80", 0, 1'b0); step();

        // Training entry 16 (0x40); lookup on the same entry shows pre-update value.
        bus.if_pc = 32'h40;
        ex(1, 1, 0, 3'b000, 32'h40, 0, 1, 0, 0, 0);
        exp_comb("train1", 0, 1, 1, 0); exp_pred("train1", 0, 1'b0); step();
        ex(1, 1, 0, 3'b000, 32'h40, 0, 1, 0, 0, 0);
        exp_comb("train2", 0, 1, 1, 0); exp_pred("train2", 0, 1'b1); step();
        ex(1, 1, 0, 3'b000, 32'h40, 1, 1, 0, 0, 0);
        exp_comb("train3", 0, 1, 0, 0); exp_pred("train3", 0, 1'b1); step();
        idle(); exp_pred("train_sat", 0, 1'b1); step();
        ex(1, 1, 0, 3'b000, 32'h40, 1, 0, 0, 0, 0);
        exp_comb("train_nt", 0, 0, 1, 0); exp_pred("train_nt", 0, 1'b1); step();
        idle(); exp_pred("after_nt", 0, 1'b1); exp_cnt("cnt_train", 0, 14, 7); step();
        bus.if_pc = 32'h140; exp_pred("alias_140", 0, 1'b1); step();
        bus.if_pc = 32'h44;  exp_pred("alias_44", 0, 1'b0); step();
        bus.if_pc = 32'h43;  exp_pred("alias_43", 0, 1'b1); step();

        // Jumps and bubbles at 0x44 (entry 17, still 01).
        bus.if_pc = 32'h44;
        ex(1, 0, 1, 3'b000, 32'h44, 0, 0, 0, 0, 0); exp_comb("jal", 0, 1, 1, 0); step();
        idle(); exp_pred("jal_no_upd", 0, 1'b0); exp_cnt("cnt_jal", 0, 15, 8); step();
        ex(1, 1, 1, 3'b001, 32'h44, 1, 1, 0, 0, 0); exp_comb("jal_and_br", 0, 1, 0, 0); step();
        ex(0, 1, 1, 3'b010, 32'h44, 0, 1, 0, 0, 0); exp_comb("bubble_a", 0, 0, 0, 0); step();
        ex(0, 1, 0, 3'b000, 32'h44, 1, 0, 0, 0, 0); exp_comb("bubble_b", 0, 0, 0, 0); step();
        idle(); exp_cnt("cnt_bubble", 0, 16, 8); step();
        ex(1, 1, 0, 3'b000, 32'h44, 0, 1, 0, 0, 0); exp_comb("beq_44", 0, 1, 1, 0); step();
        idle(); exp_pred("pred_44", 0, 1'b1); exp_cnt("cnt_44", 0, 17, 9); step();

        // CNT_W=4 saturation on dut4, then reset colliding with an update.
        for (int k = 0; k < 20; k++) begin
            ex4(1, 1, 3'b000, 32'h0, 0, 1);
            exp_comb($sformatf("sat_%0d", k), 1, 1, 1, 0);
            step();
        end
        ex4(0, 0, 3'b000, 32'h0, 0, 0);
        bus4.if_pc = 32'h0;
        exp_pred("sat_pred0", 1, 1'b1); exp_cnt("sat_cnt", 1, 15, 15); step();
        rst = 1'b1;
        ex4(1, 1, 3'b000, 32'h8, 0, 1);
        step();
        rst = 1'b0;
        ex4(0, 0, 3'b000, 32'h0, 0, 0);
        bus4.if_pc = 32'h8;
        exp_pred("rst_upd_pred8", 1, 1'b0); exp_cnt("rst_upd_cnt", 1, 0, 0); step();
        bus4.if_pc = 32'h0;
        exp_pred("rst_pred0", 1, 1'b0); step();

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
